// File: rtl/register_file_if.sv
// Register file access bundle: one write port and two independent read ports.
//
// Signals:
//   write_enable  - commit write_data into register write_index at the clock edge
//   write_index   - register selected for writing
//   write_data    - value to store
//   read_index_a  - register selected for read port A
//   read_data_a   - contents of register read_index_a (combinational)
//   read_index_b  - register selected for read port B
//   read_data_b   - contents of register read_index_b (combinational)
//
// Modports: master drives indices/write data; slave (the register file) returns read data.
interface register_file_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 2
);
    logic                   write_enable;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [DATA_WIDTH-1:0]  write_data;
    logic [INDEX_WIDTH-1:0] read_index_a;
    logic [DATA_WIDTH-1:0]  read_data_a;
    logic [INDEX_WIDTH-1:0] read_index_b;
    logic [DATA_WIDTH-1:0]  read_data_b;

    modport master (
        output write_enable, write_index, write_data, read_index_a, read_index_b,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  write_enable, write_index, write_data, read_index_a, read_index_b,
        output read_data_a, read_data_b
    );
endinterface

// File: rtl/register_file.sv
// Register file: 2**INDEX_WIDTH registers of DATA_WIDTH bits, one synchronous write port and
// two asynchronous (combinational) read ports. Every register, including register 0, is
// writable.
//
// Ports:
//   clk   - clock; all state updates on its rising edge
//   reset - synchronous active-high clear of every register; overrides a same-cycle write
//   bus   - register_file_if.slave carrying the write port and both read ports
//
// Configuration:
//   REGISTER_FILE_WRITE_BYPASS_EN - when defined, a read of the register being written in the
//   current cycle (reset low) returns write_data combinationally. When undefined, reads
//   return stored contents only, so the new value appears after the writing edge.
module register_file #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 2
) (
    input logic           clk,
    input logic           reset,
    register_file_if.slave bus
);
    localparam int NUM_REGS = 2 ** INDEX_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] read_a;
    logic [DATA_WIDTH-1:0] read_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.write_enable) begin
            regs_q[bus.write_index] <= bus.write_data;
        end
    end

    always_comb begin
        read_a = regs_q[bus.read_index_a];
        read_b = regs_q[bus.read_index_b];
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        // Write-through: forward data that will be stored at the coming edge.
        if (!reset && bus.write_enable) begin
            if (bus.read_index_a == bus.write_index) read_a = bus.write_data;
            if (bus.read_index_b == bus.write_index) read_b = bus.write_data;
        end
`endif
    end

    assign bus.read_data_a = read_a;
    assign bus.read_data_b = read_b;
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 16-bit data, 4 registers).
module tb_register_file;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    register_file_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

    register_file #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.write_enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.read_index_a = i[IW-1:0];
            bus.read_index_b = i[IW-1:0];
            #1;
            checks++;
            if (bus.read_data_a !== 16'h0000) begin
                $display("FAIL reset_a idx%0d got %h want 0000", i, bus.read_data_a);
                errors++;
            end
            checks++;
            if (bus.read_data_b !== 16'h0000) begin
                $display("FAIL reset_b idx%0d got %h want 0000", i, bus.read_data_b);
                errors++;
            end
        end
    endtask

    task automatic test_write_read();
        bus.write_enable = 1'b1;
        bus.write_index  = 2'd0;
        bus.write_data   = 16'd3;
        bus.read_index_a = 2'd1;
        tick();
        checks++;
        if (bus.read_data_a !== 16'd0) begin
            $display("FAIL write_read_idx1 got %h want 0000", bus.read_data_a);
            errors++;
        end
        bus.read_index_a = 2'd0;
        bus.write_index  = 2'd1;
        bus.write_data   = 16'd7;
        tick();
        checks++;
        if (bus.read_data_a !== 16'd3) begin
            $display("FAIL write_read_idx0 got %h want 0003", bus.read_data_a);
            errors++;
        end
        bus.write_enable = 1'b0;
    endtask

    task automatic test_write_disable();
        bus.read_index_a = 2'd1;
        bus.write_enable = 1'b0;
        bus.write_index  = 2'd0;
        bus.write_data   = 16'd10;
        tick();
        checks++;
        if (bus.read_data_a !== 16'd7) begin
            $display("FAIL wdis_idx1 got %h want 0007", bus.read_data_a);
            errors++;
        end
        bus.read_index_b = 2'd0;
        #1;
        checks++;
        if (bus.read_data_b !== 16'd3) begin
            $display("FAIL wdis_idx0 got %h want 0003", bus.read_data_b);
            errors++;
        end
    endtask

    task automatic test_dual_read();
        bus.write_enable = 1'b1;
        bus.write_index  = 2'd2;
        bus.write_data   = 16'hA5A5;
        tick();
        bus.write_index  = 2'd3;
        bus.write_data   = 16'hFFFF;
        tick();
        bus.write_enable = 1'b0;
        bus.read_index_a = 2'd2;
        bus.read_index_b = 2'd3;
        #1;
        checks++;
        if (bus.read_data_a !== 16'hA5A5) begin
            $display("FAIL dual_a got %h want a5a5", bus.read_data_a);
            errors++;
        end
        checks++;
        if (bus.read_data_b !== 16'hFFFF) begin
            $display("FAIL dual_b got %h want ffff", bus.read_data_b);
            errors++;
        end
        // Both ports on the same register, and the earlier registers untouched.
        bus.read_index_a = 2'd1;
        bus.read_index_b = 2'd1;
        #1;
        checks++;
        if (bus.read_data_a !== 16'd7 || bus.read_data_b !== 16'd7) begin
            $display("FAIL dual_same got %h/%h want 0007/0007", bus.read_data_a,
                     bus.read_data_b);
            errors++;
        end
    endtask

    task automatic test_reset_priority();
        reset            = 1'b1;
        bus.write_enable = 1'b1;
        bus.write_index  = 2'd2;
        bus.write_data   = 16'h1234;
        tick();
        reset            = 1'b0;
        bus.write_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.read_index_a = i[IW-1:0];
            bus.read_index_b = 2'(3 - i);
            #1;
            checks++;
            if (bus.read_data_a !== 16'h0000 || bus.read_data_b !== 16'h0000) begin
                $display("FAIL rst_prio idx%0d got %h/%h want 0000/0000", i,
                         bus.read_data_a, bus.read_data_b);
                errors++;
            end
        end
    endtask

    task automatic test_same_index();
        logic [DW-1:0] exp_before;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        exp_before = 16'h0055;
`else
        exp_before = 16'h0000;
`endif
        bus.read_index_a = 2'd1;
        bus.read_index_b = 2'd0;
        bus.write_enable = 1'b1;
        bus.write_index  = 2'd1;
        bus.write_data   = 16'h0055;
        #1;
        checks++;
        if (bus.read_data_a !== exp_before) begin
            $display("FAIL same_before got %h want %h", bus.read_data_a, exp_before);
            errors++;
        end
        checks++;
        if (bus.read_data_b !== 16'h0000) begin
            $display("FAIL same_other_before got %h want 0000", bus.read_data_b);
            errors++;
        end
        tick();
        bus.write_enable = 1'b0;
        #1;
        checks++;
        if (bus.read_data_a !== 16'h0055) begin
            $display("FAIL same_after got %h want 0055", bus.read_data_a);
            errors++;
        end
        checks++;
        if (bus.read_data_b !== 16'h0000) begin
            $display("FAIL same_other_after got %h want 0000", bus.read_data_b);
            errors++;
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_index  = '0;
        bus.write_data   = '0;
        bus.read_index_a = '0;
        bus.read_index_b = '0;
        test_reset();
        test_write_read();
        test_write_disable();
        test_dual_read();
        test_reset_priority();
        test_same_index();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
